mac_accumulator: RTL and testbench

Downstream stage of the 8-bit signed multiplier in the matrix coprocessor datapath. Consumes a stream of signed 8-bit products and their overflow flags, and accumulates one dot product (row × column) of configurable length into a wide internal register. It emits one saturated 8-bit matrix element with a sticky overflow flag through a valid/ready handshake.

---
 rtl/mac_accumulator.sv | 137 +++++++++++++
 tb/tb_mac_accumulator.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// mac_accumulator: accumulates a stream of signed 8-bit products into one
// saturated 8-bit dot-product element with a sticky overflow flag.
module mac_accumulator #(
    parameter int unsigned N_MAX = 5,
    parameter int unsigned ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       prod,
    input  logic             prod_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       result,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned LEN_W = 3;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc, acc_nxt, acc_sum;
    logic [LEN_W-1:0]        count, count_nxt;
    logic [LEN_W-1:0]        len_q, len_nxt;
    logic                    sticky, sticky_nxt;
    logic [7:0]              result_nxt;
    logic                    ovf_nxt;

    // Clamp the wide accumulator to the signed 8-bit range.
    function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] a);
        if (a > SAT_HI) begin
            return 8'h7F;
        end else if (a < SAT_LO) begin
            return 8'h80;
        end else begin
            return a[7:0];
        end
    endfunction

    // True when the final sum does not fit in signed 8 bits.
    function automatic logic out_of_range(input logic signed [ACC_W-1:0] a);
        return (a > SAT_HI) || (a < SAT_LO);
    endfunction

    // Next-state and datapath update.
    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        count_nxt  = count;
        len_nxt    = len_q;
        sticky_nxt = sticky;
        result_nxt = result;
        ovf_nxt    = ovf;
        acc_sum    = acc + {{(ACC_W-8){prod[7]}}, prod};

        case (state)
            IDLE: begin
                if (start) begin
                    len_nxt    = len;
                    acc_nxt    = '0;
                    count_nxt  = '0;
                    sticky_nxt = 1'b0;
                    if (len == '0) begin
                        state_nxt  = DONE;
                        result_nxt = 8'h00;
                        ovf_nxt    = 1'b0;
                    end else if (32'(len) > N_MAX) begin
                        state_nxt  = DONE;
                        result_nxt = 8'h00;
                        ovf_nxt    = 1'b1;
                    end else begin
                        state_nxt = ACC;
                    end
                end
            end
            ACC: begin
                if (in_valid && in_ready) begin
                    acc_nxt    = acc_sum;
                    sticky_nxt = sticky | prod_ovf;
                    count_nxt  = count + LEN_W'(1);
                    if (count_nxt == len_q) begin
                        state_nxt  = DONE;
                        result_nxt = sat8(acc_sum);
                        ovf_nxt    = sticky_nxt | out_of_range(acc_sum);
                    end
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            len_q     <= '0;
            sticky    <= 1'b0;
            result    <= 8'h00;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            count     <= count_nxt;
            len_q     <= len_nxt;
            sticky    <= sticky_nxt;
            result    <= result_nxt;
            ovf       <= ovf_nxt;
            out_valid <= (state_nxt == DONE);
            in_ready  <= (state_nxt == ACC);
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: directed dot products checked
// against a plain-arithmetic model plus literal expectations.
module tb_mac_accumulator;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [2:0]        len;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] prod;
    logic              prod_ovf;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        result;
    logic              ovf;
    logic              busy;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [7:0] r;
        logic       o;
    } exp_t;

    exp_t              exp_q[$];
    logic signed [7:0] pv[8];
    logic              po_v[8];

    always #5 clk = ~clk;

    mac_accumulator #(.N_MAX(5), .ACC_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .prod     (prod),
        .prod_ovf (prod_ovf),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .ovf      (ovf),
        .busy     (busy)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference: sum the products in plain integers, saturate the final value.
    task automatic model(input int l, output logic [7:0] r, output logic o);
        int s;
        logic st;
        s  = 0;
        st = 1'b0;
        if (l == 0) begin
            r = 8'd0; o = 1'b0;
        end else if (l > 5) begin
            r = 8'd0; o = 1'b1;
        end else begin
            for (int i = 0; i < l; i++) begin
                s  = s + int'(pv[i]);
                st = st | po_v[i];
            end
            if (s > 127) begin
                r = 8'h7F; o = 1'b1;
            end else if (s < -128) begin
                r = 8'h80; o = 1'b1;
            end else begin
                r = 8'(s); o = st;
            end
        end
    endtask

    task automatic load(input int a, input int b, input int c, input int d, input int e);
        pv[0] = 8'(a); pv[1] = 8'(b); pv[2] = 8'(c); pv[3] = 8'(d); pv[4] = 8'(e);
        pv[5] = 8'd0;  pv[6] = 8'd0;  pv[7] = 8'd0;
        for (int i = 0; i < 8; i++) po_v[i] = 1'b0;
    endtask

    // Compare DUT result/ovf to the model every cycle the output is valid.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                check("cmp_result", 32'(result), 32'(exp_q[0].r));
                check("cmp_ovf", 32'(ovf), 32'(exp_q[0].o));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // One dot product: start, feed beats (optionally every other cycle),
    // optionally stall the consumer, then confirm return to IDLE.
    task automatic run(input string nm, input int l, input bit tog, input int hold,
                       input logic [7:0] lit_r, input logic lit_o);
        logic [7:0] mr;
        logic       mo;
        int         cnum;
        int         beats;
        model(l, mr, mo);
        check({nm, "_model_r"}, 32'(mr), 32'(lit_r));
        check({nm, "_model_o"}, 32'(mo), 32'(lit_o));
        exp_q.push_back('{r: mr, o: mo});
        out_ready = (hold == 0);
        @(posedge clk); #1;
        start = 1'b1;
        len   = 3'(l);
        @(posedge clk); #1;
        start = 1'b0;
        cnum  = 1;
        beats = 0;
        if (l >= 1 && l <= 5) begin
            while (beats < l && cnum < 40) begin
                check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
                check({nm, "_early_valid"}, 32'(out_valid), 32'd0);
                in_valid = tog ? 1'(cnum % 2 == 1) : 1'b1;
                prod     = pv[beats];
                prod_ovf = po_v[beats];
                @(posedge clk); #1;
                if (in_valid) beats++;
                cnum++;
            end
            in_valid = 1'b0;
            prod_ovf = 1'b0;
            if (cnum >= 40) check({nm, "_beat_timeout"}, 32'(cnum), 32'd0);
        end
        check({nm, "_out_valid"}, 32'(out_valid), 32'd1);
        check({nm, "_lit_result"}, 32'(result), 32'(lit_r));
        check({nm, "_lit_ovf"}, 32'(ovf), 32'(lit_o));
        for (int h = 0; h < hold; h++) begin
            check({nm, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            check({nm, "_hold_busy"}, 32'(busy), 32'd1);
            check({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
            start    = 1'b1;
            len      = 3'd1;
            in_valid = 1'b1;
            prod     = 8'sd99;
            @(posedge clk); #1;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({nm, "_idle_valid"}, 32'(out_valid), 32'd0);
        check({nm, "_idle_busy"}, 32'(busy), 32'd0);
        check({nm, "_idle_in_ready"}, 32'(in_ready), 32'd0);
        check({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = 3'd0;
        in_valid  = 1'b0;
        prod      = 8'sd0;
        prod_ovf  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        load(10, 20, 30, 0, 0);
        run("basic", 3, 1'b0, 0, 8'd60, 1'b0);
        load(100, 100, 0, 0, 0);
        run("sat_pos", 2, 1'b0, 0, 8'h7F, 1'b1);
        load(-100, -100, 50, 0, 0);
        run("sat_neg", 3, 1'b0, 0, 8'h80, 1'b1);
        load(100, 100, -100, 0, 0);
        run("recover", 3, 1'b0, 0, 8'd100, 1'b0);
        load(1, 2, 3, 4, 5);
        po_v[1] = 1'b1;
        run("sticky", 5, 1'b0, 0, 8'd15, 1'b1);
        load(1, 2, 3, 4, 5);
        run("full5", 5, 1'b0, 0, 8'd15, 1'b0);
        load(7, -3, 9, -20, 0);
        run("toggle", 4, 1'b1, 0, 8'(-7), 1'b0);
        load(5, 5, 5, 0, 0);
        run("hold", 3, 1'b0, 3, 8'd15, 1'b0);
        load(0, 0, 0, 0, 0);
        run("len0", 0, 1'b0, 0, 8'd0, 1'b0);
        run("len6", 6, 1'b0, 0, 8'd0, 1'b1);

        // Abort a dot product after two beats.
        load(5, 6, 7, 8, 0);
        @(posedge clk); #1;
        start = 1'b1;
        len   = 3'd4;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        prod     = pv[0];
        @(posedge clk); #1;
        prod = pv[1];
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        load(-7, 0, 0, 0, 0);
        run("after_abort", 1, 1'b0, 0, 8'(-7), 1'b0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
